// File: rtl/eth_rx_addr_filter_if.sv
// ---------------------------------------------------------------------------
// eth_rx_addr_filter_if
//   Byte-enabled 64-bit AXI-Stream link used on both sides of the RX
//   destination-address filter.
//
//   Signals
//     tdata  [63:0]  frame data, byte0 (first on wire) in [7:0]
//     tkeep  [7:0]   byte enables, contiguous from bit 0
//     tlast          last beat of frame
//     tuser          bad-frame flag, meaningful on the tlast beat only
//     tvalid         beat valid (source -> sink)
//     tready         beat accepted (sink -> source)
//
//   Modports
//     master  drives the beat, samples tready
//     slave   samples the beat, drives tready
// ---------------------------------------------------------------------------
interface eth_rx_addr_filter_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface : eth_rx_addr_filter_if

// File: rtl/eth_rx_addr_filter.sv
// ---------------------------------------------------------------------------
// eth_rx_addr_filter
//   Receive-path destination-address filter sitting between the 10G MAC RX
//   stream and the RX interface FIFO block, entirely in the rx_clk domain.
//     - Whole frames whose destination address matches no accept rule are
//       discarded (still handshaked so the MAC never stalls on them).
//     - Forwarded frames are length-checked; an oversize frame is flagged
//       bad through tuser on its tlast beat.
//     - One registered output stage plus a one-beat skid buffer give full
//       tready backpressure without bubbles.
//
//   Parameters
//     C_LEN_W   width of the byte-length counter and cfg_max_len
//               (counter saturates at 2^C_LEN_W-1)
//     C_STAT_W  width of the statistics counters
//
//   Ports
//     rx_clk             only clock
//     rx_reset           asynchronous, active-high reset
//     mac_rx             slave  stream from the MAC
//     rx_axis_mac        master stream to the interface FIFO block
//     cfg_mac_addr[47:0] station address, [47:40] = first DA byte on wire
//     cfg_promisc        accept every frame of at least 6 bytes
//     cfg_bcast_en       accept the broadcast DA
//     cfg_mcast_en       accept non-broadcast DAs with the I/G bit set
//     cfg_max_len        largest legal frame in bytes, FCS included
//     stat_pass_cnt      frames forwarded
//     stat_drop_cnt      frames rejected by the filter
//     stat_oversize_cnt  forwarded frames flagged oversize
//
//   Build option
//     ETH_RX_FILTER_STATS_EN  when defined, the three stat_* counters exist
//                             and wrap modulo 2^C_STAT_W; otherwise the
//                             stat_* outputs are tied to zero.
// ---------------------------------------------------------------------------
module eth_rx_addr_filter #(
    parameter int C_LEN_W  = 14,
    parameter int C_STAT_W = 32
) (
    input  logic                  rx_clk,
    input  logic                  rx_reset,

    eth_rx_addr_filter_if.slave   mac_rx,
    eth_rx_addr_filter_if.master  rx_axis_mac,

    input  logic [47:0]           cfg_mac_addr,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,
    input  logic [C_LEN_W-1:0]    cfg_max_len,

    output logic [C_STAT_W-1:0]   stat_pass_cnt,
    output logic [C_STAT_W-1:0]   stat_drop_cnt,
    output logic [C_STAT_W-1:0]   stat_oversize_cnt
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_SOF  = 2'd0,   // waiting for the first beat of a frame
        ST_PASS = 2'd1,   // frame accepted, forwarding the remainder
        ST_DROP = 2'd2    // frame rejected, swallowing the remainder
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    localparam logic [C_LEN_W-1:0] LEN_SAT = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_q;
    logic [C_LEN_W-1:0]   len_q;
    logic [C_LEN_W-1:0]   max_len_q;     // cfg_max_len captured at SOF

    beat_t                out_q,        out_d;
    logic                 out_valid_q,  out_valid_d;
    beat_t                skid_q,       skid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 in_ready_q,   in_ready_d;

    // -----------------------------------------------------------------------
    // Input handshake
    // -----------------------------------------------------------------------
    logic in_fire;

    // Registered so that tready is low throughout reset and rises on the
    // first edge after release.
    assign mac_rx.tready = in_ready_q;
    assign in_fire       = mac_rx.tvalid & in_ready_q;

    // -----------------------------------------------------------------------
    // Address decision for the first beat
    // -----------------------------------------------------------------------
    logic [47:0] rx_da;
    logic        da_is_bcast;
    logic        sof_accept;

    // The first DA byte on the wire sits in tdata[7:0] but in cfg_mac_addr[47:40].
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        rx_da = '0;
        for (int i = 0; i < 6; i++) begin
            rx_da[47-8*i -: 8] = mac_rx.tdata[8*i +: 8];
        end
    end

    assign da_is_bcast = &rx_da;

    // A first beat shorter than 6 bytes carries no complete DA; it is rejected
    // even in promiscuous mode.
    assign sof_accept = mac_rx.tkeep[5] &
                        ( cfg_promisc
                        | (rx_da == cfg_mac_addr)
                        | (cfg_bcast_en & da_is_bcast)
                        | (cfg_mcast_en & mac_rx.tdata[0] & ~da_is_bcast));

    // -----------------------------------------------------------------------
    // Length accounting
    // -----------------------------------------------------------------------
    logic [3:0]          beat_bytes;
    logic [C_LEN_W-1:0]  len_base;
    logic [C_LEN_W:0]    len_sum;
    logic [C_LEN_W-1:0]  len_next;
    logic [C_LEN_W-1:0]  max_len_eff;
    logic                oversize;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < 8; i++) begin
            beat_bytes = beat_bytes + {3'b000, mac_rx.tkeep[i]};
        end
    end

    // The counter restarts at every SOF beat; the carry bit signals that the
    // running sum has passed the counter range and must saturate.
    assign len_base    = (state_q == ST_SOF) ? '0 : len_q;
    assign len_sum     = {1'b0, len_base} + {{(C_LEN_W-3){1'b0}}, beat_bytes};
    assign len_next    = len_sum[C_LEN_W] ? LEN_SAT : len_sum[C_LEN_W-1:0];

    // A single-beat frame compares against the live limit; longer frames use
    // the limit captured at their SOF so mid-frame changes wait a frame.
    assign max_len_eff = (state_q == ST_SOF) ? cfg_max_len : max_len_q;
    assign oversize    = (len_next > max_len_eff);

    // -----------------------------------------------------------------------
    // Forwarding decision and outgoing beat
    // -----------------------------------------------------------------------
    logic  fwd_en;
    beat_t fwd_beat;

    assign fwd_en = in_fire & (((state_q == ST_SOF) & sof_accept) | (state_q == ST_PASS));

    always_comb begin
        fwd_beat      = '0;
        fwd_beat.data = mac_rx.tdata;
        fwd_beat.keep = mac_rx.tkeep;
        fwd_beat.last = mac_rx.tlast;
        fwd_beat.user = mac_rx.tlast & (mac_rx.tuser | oversize);
    end

    // -----------------------------------------------------------------------
    // Frame FSM and length counter; advance only on accepted input beats
    // -----------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rx_reset) begin
            state_q   <= ST_SOF;
            len_q     <= '0;
            max_len_q <= '0;
        end else if (in_fire) begin
            case (state_q)
                ST_SOF: begin
                    max_len_q <= cfg_max_len;
                    len_q     <= mac_rx.tlast ? '0 : len_next;
                    if (mac_rx.tlast) begin
                        state_q <= ST_SOF;
                    end else begin
                        state_q <= sof_accept ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS: begin
                    len_q <= mac_rx.tlast ? '0 : len_next;
                    if (mac_rx.tlast) begin
                        state_q <= ST_SOF;
                    end
                end
                ST_DROP: begin
                    if (mac_rx.tlast) begin
                        state_q <= ST_SOF;
                    end
                end
                default: begin
                    state_q <= ST_SOF;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register with one-beat skid buffer
    // -----------------------------------------------------------------------
    logic out_free;

    // The output register may take a new beat when empty or being consumed.
    assign out_free = ~out_valid_q | rx_axis_mac.tready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (out_free) begin
            if (skid_valid_q) begin
                // Input is stalled while the skid is full, so no new beat
                // competes with the drain.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = fwd_en;
                if (fwd_en) begin
                    out_d = fwd_beat;
                end
            end
        end else if (fwd_en) begin
            skid_d       = fwd_beat;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge rx_clk or posedge rx_reset) begin
        // NOTE: the skid data flops are reset along with the output register;
        // the stage is only two beats deep and it keeps the outputs and
        // internal state fully defined the moment reset asserts.
        if (rx_reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign rx_axis_mac.tdata  = out_q.data;
    assign rx_axis_mac.tkeep  = out_q.keep;
    assign rx_axis_mac.tlast  = out_q.last;
    assign rx_axis_mac.tuser  = out_q.user;
    assign rx_axis_mac.tvalid = out_valid_q;

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef ETH_RX_FILTER_STATS_EN
    logic                pass_evt;
    logic                drop_evt;
    logic                ovs_evt;
    logic [C_STAT_W-1:0] pass_cnt_q;
    logic [C_STAT_W-1:0] drop_cnt_q;
    logic [C_STAT_W-1:0] ovs_cnt_q;

    // Events are counted where the beat is accepted from the MAC; the skid
    // stage never loses or duplicates a forwarded beat.
    assign pass_evt = fwd_en & mac_rx.tlast;
    assign ovs_evt  = pass_evt & oversize;
    assign drop_evt = in_fire & (state_q == ST_SOF) & ~sof_accept;

    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
            ovs_cnt_q  <= '0;
        end else begin
            if (pass_evt) pass_cnt_q <= pass_cnt_q + 1'b1;
            if (drop_evt) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (ovs_evt)  ovs_cnt_q  <= ovs_cnt_q + 1'b1;
        end
    end

    assign stat_pass_cnt     = pass_cnt_q;
    assign stat_drop_cnt     = drop_cnt_q;
    assign stat_oversize_cnt = ovs_cnt_q;
`else
    assign stat_pass_cnt     = '0;
    assign stat_drop_cnt     = '0;
    assign stat_oversize_cnt = '0;
`endif

endmodule : eth_rx_addr_filter

// File: tb/tb_eth_rx_addr_filter.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_addr_filter
//   Self-checking bench for eth_rx_addr_filter. Frames are built as byte
//   lists; a frame-level model (DA rules, total byte count, saturation)
//   predicts the forwarded beat stream and the statistics counters.
// ---------------------------------------------------------------------------
module tb_eth_rx_addr_filter;

    localparam int LEN_W  = 14;
    localparam int STAT_W = 32;
    localparam int LEN_SAT = (1 << LEN_W) - 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic rx_clk = 1'b0;
    logic rx_reset = 1'b1;

    eth_rx_addr_filter_if mac_if ();
    eth_rx_addr_filter_if out_if ();

    logic [47:0]       cfg_mac_addr;
    logic              cfg_promisc;
    logic              cfg_bcast_en;
    logic              cfg_mcast_en;
    logic [LEN_W-1:0]  cfg_max_len;
    logic [STAT_W-1:0] stat_pass_cnt;
    logic [STAT_W-1:0] stat_drop_cnt;
    logic [STAT_W-1:0] stat_oversize_cnt;

    eth_rx_addr_filter #(
        .C_LEN_W  (LEN_W),
        .C_STAT_W (STAT_W)
    ) dut (
        .rx_clk            (rx_clk),
        .rx_reset          (rx_reset),
        .mac_rx            (mac_if),
        .rx_axis_mac       (out_if),
        .cfg_mac_addr      (cfg_mac_addr),
        .cfg_promisc       (cfg_promisc),
        .cfg_bcast_en      (cfg_bcast_en),
        .cfg_mcast_en      (cfg_mcast_en),
        .cfg_max_len       (cfg_max_len),
        .stat_pass_cnt     (stat_pass_cnt),
        .stat_drop_cnt     (stat_drop_cnt),
        .stat_oversize_cnt (stat_oversize_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int pass_cnt  = 0;
    int check_cnt = 0;

    beat_t exp_q[$];
    beat_t out_q[$];
    int    in_cyc_q[$];
    int    out_cyc_q[$];

    logic [7:0] frame[$];
    beat_t      fbeats[$];

    logic [STAT_W-1:0] exp_pass = '0;
    logic [STAT_W-1:0] exp_drop = '0;
    logic [STAT_W-1:0] exp_ovs  = '0;

    int   cyc        = 0;
    int   rst_age    = 0;
    bit   rand_ready = 1'b0;
    logic ready_fixed = 1'b1;
    bit   prev_held  = 1'b0;
    int   stall_err  = 0;
    bit   stall_seen = 1'b0;

    localparam logic [47:0] STATION = 48'h000a35010203;
    localparam logic [47:0] BCAST   = 48'hffffffffffff;

    always @(posedge rx_clk) begin
        cyc     <= cyc + 1;
        rst_age <= rx_reset ? 0 : rst_age + 1;
    end

    // Downstream sink: pick tready for the coming edge, then record the beat
    // that edge will transfer. Also watches that input stalls only follow a
    // held output beat (the only way the skid can be occupied).
    always @(negedge rx_clk) begin
        beat_t b;
        out_if.tready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
        if (!rx_reset && rst_age > 0 && mac_if.tready !== 1'b1) begin
            stall_seen = 1'b1;
            if (!prev_held) stall_err++;
        end
        if (!rx_reset && out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
            b.data = out_if.tdata;
            b.keep = out_if.tkeep;
            b.last = out_if.tlast;
            b.user = out_if.tuser;
            out_q.push_back(b);
            out_cyc_q.push_back(cyc);
        end
        prev_held = (out_if.tvalid === 1'b1) && !out_if.tready;
    end

    // ---------------------------------------------------------------------
    // Frame construction and reference model
    // ---------------------------------------------------------------------
    task automatic build_frame(input int len, input logic [47:0] da, input bit bad);
        beat_t b;
        frame.delete();
        fbeats.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) frame.push_back(da[47-8*i -: 8]);
            else       frame.push_back(8'($urandom));
        end
        for (int i = 0; i < len; i += 8) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < len) begin
                    b.data[8*j +: 8] = frame[i+j];
                    b.keep[j]        = 1'b1;
                end
            end
            b.last = (i + 8 >= len);
            // Non-last tuser is junk the filter must not propagate.
            b.user = b.last ? bad : 1'($urandom);
            fbeats.push_back(b);
        end
    endtask

    // Decides the fate of the whole frame from its bytes and the current
    // configuration, then appends the expected output beats.
    task automatic model_frame(input bit bad);
        logic [47:0] da;
        bit          accept;
        int          tot;
        bit          ovs;
        beat_t       e;
        tot = frame.size();
        da  = '0;
        for (int i = 0; i < 6 && i < tot; i++) da = {da[39:0], frame[i]};
        accept = (tot >= 6) &&
                 (cfg_promisc || da == cfg_mac_addr ||
                  (cfg_bcast_en && da == BCAST) ||
                  (cfg_mcast_en && frame[0][0] && da != BCAST));
        if (!accept) begin
            exp_drop++;
            return;
        end
        if (tot > LEN_SAT) tot = LEN_SAT;
        ovs = (tot > int'(cfg_max_len));
        exp_pass++;
        if (ovs) exp_ovs++;
        foreach (fbeats[k]) begin
            e      = fbeats[k];
            e.user = e.last ? (bad | ovs) : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic drive_beat(input beat_t b);
        int n;
        n = 0;
        mac_if.tdata  = b.data;
        mac_if.tkeep  = b.keep;
        mac_if.tlast  = b.last;
        mac_if.tuser  = b.user;
        mac_if.tvalid = 1'b1;
        while (mac_if.tready !== 1'b1 && n < 200) begin
            @(negedge rx_clk);
            n++;
        end
        if (n >= 200) begin
            check_cnt++;
            $display("FAIL drive_timeout: mac_rx_tready=%b after %0d cycles, required 1", mac_if.tready, n);
            mac_if.tvalid = 1'b0;
            return;
        end
        in_cyc_q.push_back(cyc);
        @(negedge rx_clk);
        mac_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [47:0] da, input bit bad, input bit mid_cfg);
        logic [47:0]      sv_addr;
        logic [LEN_W-1:0] sv_max;
        build_frame(len, da, bad);
        model_frame(bad);
        sv_addr = cfg_mac_addr;
        sv_max  = cfg_max_len;
        foreach (fbeats[k]) begin
            drive_beat(fbeats[k]);
            if (mid_cfg && k == 0) begin
                cfg_mac_addr = ~cfg_mac_addr;
                cfg_max_len  = 1;
            end
        end
        cfg_mac_addr = sv_addr;
        cfg_max_len  = sv_max;
    endtask

    task automatic compare_stream(input string name, input bit chk_lat);
        int n;
        int m;
        n = 0;
        while (out_q.size() < exp_q.size() && n < 5000) begin
            @(negedge rx_clk);
            n++;
        end
        repeat (10) @(negedge rx_clk);
        check_cnt++;
        if (out_q.size() !== exp_q.size())
            $display("FAIL %s_count: got %0d beats, required %0d", name, out_q.size(), exp_q.size());
        else
            pass_cnt++;
        m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check_cnt++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL %s_beat%0d: got %h, required %h", name, i, out_q[i], exp_q[i]);
            else
                pass_cnt++;
        end
        if (chk_lat) begin
            for (int i = 0; i < m && i < in_cyc_q.size(); i++) begin
                check_cnt++;
                if (out_cyc_q[i] !== in_cyc_q[i] + 1)
                    $display("FAIL %s_latency%0d: out cycle %0d, required %0d", name, i, out_cyc_q[i], in_cyc_q[i] + 1);
                else
                    pass_cnt++;
            end
        end
        exp_q.delete();
        out_q.delete();
        in_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic check_stats(input string name);
        logic [STAT_W-1:0] ep, ed, eo;
`ifdef ETH_RX_FILTER_STATS_EN
        ep = exp_pass; ed = exp_drop; eo = exp_ovs;
`else
        ep = '0; ed = '0; eo = '0;
`endif
        check_cnt++;
        if (stat_pass_cnt !== ep) $display("FAIL %s_pass_cnt: got %0d, required %0d", name, stat_pass_cnt, ep);
        else pass_cnt++;
        check_cnt++;
        if (stat_drop_cnt !== ed) $display("FAIL %s_drop_cnt: got %0d, required %0d", name, stat_drop_cnt, ed);
        else pass_cnt++;
        check_cnt++;
        if (stat_oversize_cnt !== eo) $display("FAIL %s_ovs_cnt: got %0d, required %0d", name, stat_oversize_cnt, eo);
        else pass_cnt++;
    endtask

    task automatic check_outputs_idle(input string name);
        check_cnt++;
        if ({out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser} !== 74'd0)
            $display("FAIL %s_outputs: got valid=%b data=%h keep=%h last=%b user=%b, required all 0",
                     name, out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser);
        else
            pass_cnt++;
        check_cnt++;
        if (mac_if.tready !== 1'b0) $display("FAIL %s_tready: got %b, required 0", name, mac_if.tready);
        else pass_cnt++;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        mac_if.tvalid = 1'b0;
        mac_if.tdata  = '0;
        mac_if.tkeep  = '0;
        mac_if.tlast  = 1'b0;
        mac_if.tuser  = 1'b0;
        cfg_mac_addr  = STATION;
        cfg_promisc   = 1'b0;
        cfg_bcast_en  = 1'b0;
        cfg_mcast_en  = 1'b0;
        cfg_max_len   = 14'd1518;
        rx_reset      = 1'b1;
        repeat (3) @(negedge rx_clk);
        check_outputs_idle("reset");
        check_stats("reset");
        rx_reset = 1'b0;
        repeat (2) @(negedge rx_clk);
        check_cnt++;
        if (mac_if.tready !== 1'b1) $display("FAIL reset_release_tready: got %b, required 1", mac_if.tready);
        else pass_cnt++;
    endtask

    task automatic test_match();
        ready_fixed = 1'b1;
        send_frame(64, STATION, 1'b0, 1'b0);
        compare_stream("match", 1'b1);
        check_stats("match");
    endtask

    task automatic test_drop_back_to_back();
        stall_seen = 1'b0;
        send_frame(64, 48'h000a35010204, 1'b1, 1'b0);
        send_frame(64, STATION, 1'b0, 1'b0);
        compare_stream("drop_b2b", 1'b0);
        check_cnt++;
        if (stall_seen !== 1'b0) $display("FAIL drop_tready: saw mac_rx_tready=0, required constant 1");
        else pass_cnt++;
        check_stats("drop_b2b");
    endtask

    task automatic test_bcast_mcast();
        cfg_bcast_en = 1'b0;
        send_frame(60, BCAST, 1'b0, 1'b0);
        cfg_bcast_en = 1'b1;
        send_frame(60, BCAST, 1'b0, 1'b0);
        cfg_mcast_en = 1'b1;
        send_frame(70, 48'h01005e0000fb, 1'b0, 1'b0);
        // Broadcast is not a multicast hit on its own.
        cfg_bcast_en = 1'b0;
        send_frame(60, BCAST, 1'b0, 1'b0);
        cfg_mcast_en = 1'b0;
        // Promiscuous still needs a full DA in the first beat.
        cfg_promisc = 1'b1;
        send_frame(5, 48'h123456789abc, 1'b0, 1'b0);
        send_frame(6, 48'h123456789abc, 1'b0, 1'b0);
        cfg_promisc = 1'b0;
        compare_stream("bcast_mcast", 1'b0);
        check_stats("bcast_mcast");
    endtask

    task automatic test_oversize();
        cfg_max_len = 14'd1518;
        send_frame(1519, STATION, 1'b0, 1'b0);
        send_frame(1518, STATION, 1'b0, 1'b0);
        send_frame(100, STATION, 1'b1, 1'b0);
        compare_stream("oversize", 1'b0);
        // Length counter saturates rather than wrapping.
        cfg_max_len = 14'd100;
        send_frame(16390, STATION, 1'b0, 1'b0);
        cfg_max_len = 14'(LEN_SAT);
        send_frame(16390, STATION, 1'b0, 1'b0);
        cfg_max_len = 14'd1518;
        compare_stream("saturate", 1'b0);
        check_stats("oversize");
    endtask

    task automatic test_cfg_midframe();
        send_frame(40, STATION, 1'b0, 1'b1);
        compare_stream("cfg_midframe", 1'b0);
    endtask

    task automatic test_random();
        logic [47:0] da;
        int          len;
        rand_ready = 1'b1;
        stall_err  = 0;
        for (int f = 0; f < 100; f++) begin
            cfg_promisc  = ($urandom_range(0, 4) == 0);
            cfg_bcast_en = 1'($urandom);
            cfg_mcast_en = 1'($urandom);
            cfg_max_len  = 14'($urandom_range(60, 180));
            case ($urandom_range(0, 4))
                0:       da = STATION;
                1:       da = STATION ^ (48'h1 << $urandom_range(1, 47));
                2:       da = BCAST;
                3:       da = {24'h01005e, 24'($urandom)};
                default: da = {16'($urandom), 32'($urandom)};
            endcase
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 200);
            send_frame(len, da, ($urandom_range(0, 7) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge rx_clk);
        end
        compare_stream("random", 1'b0);
        check_cnt++;
        if (stall_err !== 0) $display("FAIL random_tready: %0d stalls without held output, required 0", stall_err);
        else pass_cnt++;
        check_stats("random");
        rand_ready   = 1'b0;
        cfg_promisc  = 1'b0;
        cfg_bcast_en = 1'b0;
        cfg_mcast_en = 1'b0;
        cfg_max_len  = 14'd1518;
    endtask

    task automatic test_reset_midframe();
        build_frame(64, STATION, 1'b0);
        for (int k = 0; k < 3; k++) drive_beat(fbeats[k]);
        rx_reset = 1'b1;
        #1;
        check_outputs_idle("midreset");
        check_stats("midreset_zero");
        repeat (3) @(negedge rx_clk);
        exp_q.delete();
        out_q.delete();
        in_cyc_q.delete();
        out_cyc_q.delete();
        exp_pass = '0;
        exp_drop = '0;
        exp_ovs  = '0;
        rx_reset = 1'b0;
        repeat (2) @(negedge rx_clk);
        cfg_max_len = 14'd1518;
        send_frame(1519, STATION, 1'b0, 1'b0);
        compare_stream("after_reset", 1'b1);
        check_stats("after_reset");
    endtask

    initial begin
        test_reset();
        test_match();
        test_drop_back_to_back();
        test_bcast_mcast();
        test_oversize();
        test_cfg_midframe();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_eth_rx_addr_filter
